// File: rtl/i2s_tx_multichannel.sv
// Multichannel I2S / left-justified serial audio transmitter with a pending+active frame buffer.
// Every codec pin is derived from one free-running frame counter and registered once.
module i2s_tx_multichannel #(
   parameter int SAMPLE_W = 16,
   parameter int SLOT_W   = 16,
   parameter int CHANNELS = 2,
   parameter int MCLK_DIV = 4,
   parameter int BCK_DIV  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fmt,
   input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
   input  logic                         sample_valid,
   output logic                         sample_ready,
   output logic                         underrun,
   output logic                         audio_appsel,
   output logic                         audio_sysclk,
   output logic                         audio_bck,
   output logic                         audio_ws,
   output logic                         audio_data
);
   localparam int FRAME_W = CHANNELS * SAMPLE_W;
   localparam int P       = CHANNELS * SLOT_W;
   localparam int F       = P * BCK_DIV;
   localparam int CW      = $clog2(F);
   localparam int KW      = $clog2(P);

   logic [CW-1:0]      cnt_reg, cnt_next;
   logic               fmt_reg, fmt_eff;
   logic [FRAME_W-1:0] pending_reg, pending_next;
   logic [FRAME_W-1:0] active_reg, active_next;
   logic               pending_full_reg, pending_full_next;
   logic               load, accept, underrun_next;
   logic [KW-1:0]      p_idx, k_idx;
   logic [P-1:0]       ser_vec;
   logic               sysclk_next, bck_next, ws_next, data_next;
   logic               sysclk_reg, bck_reg, ws_reg, data_reg, underrun_reg;

   // Frame flattened into transmit order: ser_vec[k] is the bit sent at bit index k.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
      for (genvar gj = 0; gj < SLOT_W; gj++) begin : g_bit
         if (gj < SAMPLE_W) begin : g_data
            assign ser_vec[gi*SLOT_W + gj] = active_next[gi*SAMPLE_W + SAMPLE_W - 1 - gj];
         end else begin : g_pad
            assign ser_vec[gi*SLOT_W + gj] = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_next = (cnt_reg == CW'(F - 1)) ? '0 : cnt_reg + CW'(1);
      // fmt only matters from the frame start onwards, so the live input is used at cnt==0.
      fmt_eff  = (cnt_reg == '0) ? fmt : fmt_reg;
      load     = fmt_eff ? (cnt_reg == '0) : (cnt_reg == CW'(BCK_DIV));
      accept   = sample_valid && !pending_full_reg;

      active_next       = active_reg;
      pending_next      = pending_reg;
      pending_full_next = pending_full_reg;
      underrun_next     = 1'b0;
      if (load) begin
         pending_full_next = 1'b0;
         if (pending_full_reg)
            active_next = pending_reg;
         else if (sample_valid)
            active_next = sample_in;
         else
            underrun_next = 1'b1;
      end else if (accept) begin
         pending_next      = sample_in;
         pending_full_next = 1'b1;
      end
   end

   always_comb begin
      p_idx = KW'(cnt_reg / CW'(BCK_DIV));
      // I2S delays data by one bit clock, so period 0 carries the last bit of the previous frame.
      if (fmt_eff)
         k_idx = p_idx;
      else
         k_idx = (p_idx == '0) ? KW'(P - 1) : p_idx - KW'(1);
      sysclk_next = (cnt_reg % CW'(MCLK_DIV)) >= CW'(MCLK_DIV / 2);
      bck_next    = (cnt_reg % CW'(BCK_DIV)) >= CW'(BCK_DIV / 2);
      ws_next     = p_idx >= KW'(P / 2);
      data_next   = ser_vec[k_idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg          <= '0;
         fmt_reg          <= 1'b0;
         pending_reg      <= '0;
         active_reg       <= '0;
         pending_full_reg <= 1'b0;
         sysclk_reg       <= 1'b0;
         bck_reg          <= 1'b0;
         ws_reg           <= 1'b0;
         data_reg         <= 1'b0;
         underrun_reg     <= 1'b0;
      end else begin
         cnt_reg          <= cnt_next;
         fmt_reg          <= fmt_eff;
         pending_reg      <= pending_next;
         active_reg       <= active_next;
         pending_full_reg <= pending_full_next;
         sysclk_reg       <= sysclk_next;
         bck_reg          <= bck_next;
         ws_reg           <= ws_next;
         data_reg         <= data_next;
         underrun_reg     <= underrun_next;
      end
   end

   assign sample_ready = !pending_full_reg;
   assign underrun     = underrun_reg;
   assign audio_appsel = 1'b1;
   assign audio_sysclk = sysclk_reg;
   assign audio_bck    = bck_reg;
   assign audio_ws     = ws_reg;
   assign audio_data   = data_reg;
endmodule

// File: tb/tb_i2s_tx_multichannel.sv
// Self-checking bench for i2s_tx_multichannel: frame-level reference model plus directed
// scenarios on a default stereo instance and a 4-channel 24-bit instance.
`timescale 1ns/1ps
module tb_i2s_tx_multichannel;
   localparam int SW = 16, SL = 16, CH = 2, MD = 4, BD = 32;
   localparam int P = CH * SL, F = P * BD;
   localparam int SW4 = 24, SL4 = 32, CH4 = 4, MD4 = 2, BD4 = 4;
   localparam int P4 = CH4 * SL4, F4 = P4 * BD4;

   logic clk = 1'b0;
   logic rst = 1'b0, fmt = 1'b0, sample_valid = 1'b0;
   logic [CH*SW-1:0] sample_in = '0;
   logic sample_ready, underrun, audio_appsel, audio_sysclk, audio_bck, audio_ws, audio_data;

   logic rst4 = 1'b0, fmt4 = 1'b0, valid4 = 1'b0;
   logic [CH4*SW4-1:0] sample_in4 = '0;
   logic ready4, underrun4, appsel4, sysclk4, bck4, ws4, data4;

   always #5 clk = ~clk;

   i2s_tx_multichannel #(.SAMPLE_W(SW), .SLOT_W(SL), .CHANNELS(CH), .MCLK_DIV(MD), .BCK_DIV(BD)) dut (
      .clk(clk), .rst(rst), .fmt(fmt), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .underrun(underrun), .audio_appsel(audio_appsel),
      .audio_sysclk(audio_sysclk), .audio_bck(audio_bck), .audio_ws(audio_ws), .audio_data(audio_data));

   i2s_tx_multichannel #(.SAMPLE_W(SW4), .SLOT_W(SL4), .CHANNELS(CH4), .MCLK_DIV(MD4), .BCK_DIV(BD4)) dut4 (
      .clk(clk), .rst(rst4), .fmt(fmt4), .sample_in(sample_in4), .sample_valid(valid4),
      .sample_ready(ready4), .underrun(underrun4), .audio_appsel(appsel4),
      .audio_sysclk(sysclk4), .audio_bck(bck4), .audio_ws(ws4), .audio_data(data4));

   int checks = 0, failures = 0;

   // Reference model state: cycles since reset release, pending queue (depth 1), playing frame.
   int m;
   logic [CH*SW-1:0] pend_q[$];
   logic [CH*SW-1:0] mdl_active;
   logic mdl_fmt, accepted, obs_ready;
   logic [5:0] exp_pins, obs_pins;   // {ready, underrun, sysclk, bck, ws, data}

   task automatic model_reset();
      m = 0;
      pend_q.delete();
      mdl_active = '0;
      mdl_fmt = 1'b0;
   endtask

   task automatic model_eval();
      int c, p, k, s, b;
      logic load, e_under, e_data;
      logic [CH*SW-1:0] sh;
      c = m % F;
      p = c / BD;
      if (c == 0) mdl_fmt = fmt;
      load = mdl_fmt ? (c == 0) : (c == BD);
      exp_pins[5] = (pend_q.size() == 0);
      e_under = 1'b0;
      accepted = 1'b0;
      if (load) begin
         if (pend_q.size() != 0) mdl_active = pend_q.pop_front();
         else if (sample_valid) begin mdl_active = sample_in; accepted = 1'b1; end
         else e_under = 1'b1;
      end else if (sample_valid && pend_q.size() == 0) begin
         pend_q.push_back(sample_in);
         accepted = 1'b1;
      end
      k = mdl_fmt ? p : (p + P - 1) % P;
      s = k / SL;
      b = k % SL;
      sh = mdl_active >> (s * SW + SW - 1 - b);
      e_data = (b < SW) ? sh[0] : 1'b0;
      exp_pins[4:0] = {e_under, (c % MD) >= MD / 2, (c % BD) >= BD / 2, p >= P / 2, e_data};
      m++;
   endtask

   task automatic tick();
      obs_ready = sample_ready;
      model_eval();
      @(posedge clk);
      #1;
      obs_pins = {obs_ready, underrun, audio_sysclk, audio_bck, audio_ws, audio_data};
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sample_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [6:0] got;
      sample_valid = 1'b1;
      fmt = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      got = {sample_ready, underrun, audio_appsel, audio_sysclk, audio_bck, audio_ws, audio_data};
      if (got !== 7'b1010000) begin
         failures++;
         $display("FAIL reset_outputs got %b expected %b", got, 7'b1010000);
      end
      checks++;
      sample_valid = 1'b0;
   endtask

   task automatic test_idle();
      int und = 0;
      do_reset();
      fmt = 1'b0;
      for (int i = 0; i < 2 * F; i++) begin
         tick();
         if (obs_pins !== exp_pins) begin
            failures++;
            if (failures < 20) $display("FAIL idle_pins m=%0d got %b expected %b", m - 1, obs_pins, exp_pins);
         end
         checks++;
         if (obs_pins[4] === 1'b1) und++;
      end
      if (und != 2) begin
         failures++;
         $display("FAIL idle_underrun_count got %0d expected 2", und);
      end
      checks++;
   endtask

   task automatic test_fmt0_frame();
      int c;
      do_reset();
      fmt = 1'b0;
      sample_in = {16'h0F0F, 16'hA5F0};
      sample_valid = 1'b1;
      for (int i = 0; i < 2 * F; i++) begin
         tick();
         if (accepted) sample_valid = 1'b0;
         if (obs_pins !== exp_pins) begin
            failures++;
            if (failures < 20) $display("FAIL fmt0_pins m=%0d got %b expected %b", m - 1, obs_pins, exp_pins);
         end
         checks++;
         c = m - 1;
         if (c == BD + BD / 2) begin
            if ({audio_ws, audio_data} !== 2'b01) begin
               failures++;
               $display("FAIL fmt0_left_msb got ws/data %b%b expected 01", audio_ws, audio_data);
            end
            checks++;
         end
         if (c == (P / 2 + 1) * BD + BD / 2) begin
            if ({audio_ws, audio_data} !== 2'b10) begin
               failures++;
               $display("FAIL fmt0_right_msb got ws/data %b%b expected 10", audio_ws, audio_data);
            end
            checks++;
         end
         if (c == F + BD / 2) begin
            if ({audio_ws, audio_data} !== 2'b01) begin
               failures++;
               $display("FAIL fmt0_right_lsb_wrap got ws/data %b%b expected 01", audio_ws, audio_data);
            end
            checks++;
         end
      end
   endtask

   task automatic test_fmt1_frame();
      logic [P-1:0] pat;
      int c;
      pat = 32'hA5F0_0F0F;
      do_reset();
      fmt = 1'b1;
      sample_in = {16'h0F0F, 16'hA5F0};
      sample_valid = 1'b1;
      for (int i = 0; i < F; i++) begin
         tick();
         if (accepted) sample_valid = 1'b0;
         if (obs_pins !== exp_pins) begin
            failures++;
            if (failures < 20) $display("FAIL fmt1_pins m=%0d got %b expected %b", m - 1, obs_pins, exp_pins);
         end
         checks++;
         c = m - 1;
         if (c % BD == BD / 2) begin
            if (audio_data !== pat[P - 1 - c / BD]) begin
               failures++;
               $display("FAIL fmt1_bit p=%0d got %b expected %b", c / BD, audio_data, pat[P - 1 - c / BD]);
            end
            checks++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int und = 0, acc = 0;
      logic [31:0] ctr;
      ctr = $urandom;
      do_reset();
      fmt = 1'b1;
      sample_in = {16'(ctr), 16'(ctr ^ 32'h5A5A)};
      sample_valid = 1'b1;
      for (int i = 0; i < 4 * F; i++) begin
         tick();
         if (accepted) begin
            acc++;
            ctr++;
            sample_in = {16'(ctr), 16'(ctr ^ 32'h5A5A)};
         end
         if (obs_pins !== exp_pins) begin
            failures++;
            if (failures < 20) $display("FAIL b2b_pins m=%0d got %b expected %b", m - 1, obs_pins, exp_pins);
         end
         checks++;
         if (obs_pins[4] === 1'b1) und++;
      end
      sample_valid = 1'b0;
      if (und != 0 || acc != 5) begin
         failures++;
         $display("FAIL b2b_flow got underruns=%0d accepts=%0d expected underruns=0 accepts=5", und, acc);
      end
      checks++;
   endtask

   task automatic test_random_stream();
      int thr = 0;
      for (int i = 0; i < 8 * F; i++) begin
         if (i % F == 0) begin
            case ($urandom_range(0, 2))
               0: thr = 0;
               1: thr = 2;
               default: thr = 100;
            endcase
            fmt = 1'($urandom_range(0, 1));
         end
         if (i % F == F / 2) fmt = 1'($urandom_range(0, 1));
         sample_valid = ($urandom_range(0, 99) < thr);
         sample_in = (CH * SW)'($urandom);
         tick();
         if (obs_pins !== exp_pins) begin
            failures++;
            if (failures < 20) $display("FAIL random_pins m=%0d got %b expected %b", m - 1, obs_pins, exp_pins);
         end
         checks++;
      end
      sample_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [6:0] got;
      do_reset();
      fmt = 1'b0;
      sample_in = (CH * SW)'($urandom) | 32'h8000_8000;
      sample_valid = 1'b1;
      for (int i = 0; i <= 600; i++) begin
         tick();
         if (accepted) sample_valid = 1'b0;
         if (obs_pins !== exp_pins) begin
            failures++;
            if (failures < 20) $display("FAIL prereset_pins m=%0d got %b expected %b", m - 1, obs_pins, exp_pins);
         end
         checks++;
      end
      #2;
      rst = 1'b0;
      #1;
      got = {sample_ready, underrun, audio_appsel, audio_sysclk, audio_bck, audio_ws, audio_data};
      if (got !== 7'b1010000) begin
         failures++;
         $display("FAIL midreset_async got %b expected %b", got, 7'b1010000);
      end
      checks++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      fmt = 1'b1;
      for (int i = 0; i < F; i++) begin
         tick();
         if (obs_pins !== exp_pins) begin
            failures++;
            if (failures < 20) $display("FAIL postreset_pins m=%0d got %b expected %b", m - 1, obs_pins, exp_pins);
         end
         checks++;
      end
   endtask

   task automatic test_four_channel();
      logic [SW4-1:0] slots [CH4];
      logic [SW4-1:0] sv;
      logic e;
      int p, s, b, und;
      slots[0] = 24'h800001;
      slots[1] = 24'h7FFFFF;
      slots[2] = 24'h000000;
      slots[3] = 24'h123456;
      sample_in4 = {slots[3], slots[2], slots[1], slots[0]};
      fmt4 = 1'b1;
      valid4 = 1'b1;
      und = 0;
      @(posedge clk);
      #1;
      rst4 = 1'b1;
      for (int c = 0; c < F4; c++) begin
         @(posedge clk);
         #1;
         valid4 = 1'b0;
         if (underrun4 === 1'b1) und++;
         if (c % BD4 == BD4 / 2) begin
            p = c / BD4;
            s = p / SL4;
            b = p % SL4;
            sv = slots[s];
            e = (b < SW4) ? sv[SW4 - 1 - b] : 1'b0;
            if (data4 !== e) begin
               failures++;
               $display("FAIL ch4_data p=%0d got %b expected %b", p, data4, e);
            end
            checks++;
            if (ws4 !== 1'(p >= P4 / 2)) begin
               failures++;
               $display("FAIL ch4_ws p=%0d got %b expected %b", p, ws4, 1'(p >= P4 / 2));
            end
            checks++;
         end
      end
      if (und != 0) begin
         failures++;
         $display("FAIL ch4_underrun got %0d expected 0", und);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_fmt0_frame();
      test_fmt1_frame();
      test_back_to_back();
      test_random_stream();
      test_mid_reset();
      test_four_channel();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2s_tx_multichannel.md
# i2s_tx_multichannel

Parametrised serial audio transmitter driving an I2S-style DAC codec, the successor to the fixed 16-bit stereo speaker driver. It accepts a full frame of CHANNELS samples through a valid/ready handshake and double-buffers it. It generates system clock, bit clock and word select from one counter, and serialises MSB-first in either I2S or left-justified format. It sits between the audio sample source (tone/synth logic) and the codec pins.

## Interface
- SAMPLE_W, 16: bits per sample (1..32).
- SLOT_W, 16: bit-clock periods per channel slot; must be ≥ SAMPLE_W; extra bits are sent as 0.
- CHANNELS, 2: slots per frame; even, ≥ 2.
- MCLK_DIV, 4: clk cycles per audio_sysclk period; even.
- BCK_DIV, 32: clk cycles per audio_bck period; even, multiple of MCLK_DIV.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- fmt  in  1  0 = I2S (data delayed 1 bck after ws edge), 1 = left-justified.
- sample_in  in  CHANNELS*SAMPLE_W  frame; slot s occupies bits [s*SAMPLE_W +: SAMPLE_W], two's complement.
- sample_valid  in  1  sample_in holds a frame.
- sample_ready  out  1  pending buffer can accept a frame.
- underrun  out  1  one-clk pulse: frame boundary reached with no new frame.
- audio_appsel  out  1  codec format select, constant 1.
- audio_sysclk  out  1  codec master clock.
- audio_bck  out  1  bit clock.
- audio_ws  out  1  word select.
- audio_data  out  1  serial data.

## Operation
- Free-running frame counter cnt, 0..F-1, F = CHANNELS*SLOT_W*BCK_DIV; wraps to 0. Bit period index p = cnt / BCK_DIV, 0..P-1, P = CHANNELS*SLOT_W.
- audio_sysclk = (cnt mod MCLK_DIV) ≥ MCLK_DIV/2; audio_bck = (cnt mod BCK_DIV) ≥ BCK_DIV/2. bck falls at each p boundary; data and ws change only there.
- audio_ws = (p ≥ P/2): low for the first half of the slots, high for the second half, in both formats.
- Bit index k = p (fmt=1) or (p−1) mod P (fmt=0). Slot s = k / SLOT_W, bit b = k mod SLOT_W. Data = active[s][SAMPLE_W−1−b] if b < SAMPLE_W, else 0.
- fmt=0: the bit at p=0 is the LSB slot bit of the previous frame's last slot, taken from the previous active frame.
- fmt is sampled at cnt==0 only. Mid-frame changes take effect at the next frame.
- Buffers: one pending register and one active register.
  - Accept when sample_valid && sample_ready; sample_ready = !pending_full.
  - Load point: the start of p=0 (fmt=1) or the start of p=1 (fmt=0).
  - At the load point, pending moves to active and pending_full clears.
  - If pending is empty but a frame is accepted in the load cycle, it bypasses directly into active and there is no underrun.
  - Otherwise active is held, so the last frame repeats, and underrun pulses for 1 clk.
- An accept and a load in the same cycle with pending full: the load empties pending. ready was low, so no data is lost.

## Timing
- Reset (rst=0, async): cnt=0, pending/active cleared, pending_full=0. Outputs: sample_ready=1, underrun=0, audio_sysclk=0, audio_bck=0, audio_ws=0, audio_data=0, audio_appsel=1.
- All outputs except audio_appsel and sample_ready are registered: each pin reflects the cnt value of the previous clk (1-cycle latency from counter).
- First frame after reset is all zeros. A frame accepted before the first load point plays in frame 0.
- Handshake latency: accepted frame appears on audio_data from the next load point, within at most F+BCK_DIV clk cycles.
- Reset asserted mid-frame: outputs drop to reset values asynchronously. Output resumes at cnt=0 after release.

## Test plan
- Reset release with defaults, no valid → bck period 32 clk, sysclk period 4 clk, ws period 1024 clk (low 512), data all 0, underrun pulses once per frame.
- fmt=0, frame L=16'hA5F0, R=16'h0F0F → after ws falls, 1 bck later the MSB '1' of A5F0 appears; R MSB follows 1 bck after ws rises; LSB of R appears at p=0 of next frame.
- fmt=1, same frame → MSB of L aligned with ws falling edge; bits match A5F0 then 0F0F exactly.
- Valid held high with an incrementing frame source → sample_ready drops after one accept; exactly one frame consumed per F clk; no underrun, no repeated or skipped frame.
- CHANNELS=4, SAMPLE_W=24, SLOT_W=32, fmt=1, slots 24'h800001/24'h7FFFFF/0/24'h123456 → each slot is 24 data bits then 8 zeros; ws high during slots 2–3.
- rst pulsed low at cnt=600 → all outputs 0 within the pulse; sample_ready=1; frame restarts at cnt=0 with zeros.
